// File: rtl/mips_register_writeback_file_pkg.sv
// Shared encodings for the register control word and the layout of one
// entry of the pending-write pipeline.
//   Port1 source     : selects rs or rt for read port 1
//   Port2 source     : selects rt or rs for read port 2
//   WriteAddr source : rt, rd, r31 (link) or reserved
//   WriteData source : ALU, memory, PC or reserved
package mips_register_writeback_file_pkg;

  localparam logic PORT1_RS = 1'b0;
  localparam logic PORT1_RT = 1'b1;
  localparam logic PORT2_RT = 1'b0;
  localparam logic PORT2_RS = 1'b1;

  localparam logic [1:0] WADDR_RT   = 2'd0;
  localparam logic [1:0] WADDR_RD   = 2'd1;
  localparam logic [1:0] WADDR_R31  = 2'd2;
  localparam logic [1:0] WADDR_RSVD = 2'd3;

  typedef enum logic [1:0] {
    WDATA_ALU    = 2'd0,
    WDATA_MEMORY = 2'd1,
    WDATA_PC     = 2'd2,
    WDATA_RSVD   = 2'd3
  } write_data_source_t;

  typedef struct packed {
    logic               valid;
    logic [4:0]         dst;
    write_data_source_t data_source;
  } pending_entry_t;

  localparam int PENDING_ENTRY_W = $bits(pending_entry_t);

endpackage

// File: rtl/mips_register_file_core.sv
// 32 x DATA_W register file: two combinational read ports, one write port.
// r0 is hardwired to zero. A read of the address being written in the same
// cycle returns the incoming write data.
//   clock, reset              : clock and synchronous active-high clear
//   write_enable/addr/data    : write port, committed on the rising edge
//   read_addr1/2, read_data1/2: combinational read ports with bypass
module mips_register_file_core #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [4:0]        write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_addr1,
  input  logic [4:0]        read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_enable && (write_addr != 5'd0)) begin
      regs[write_addr] <= write_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0)
      return '0;
    else if (write_enable && (write_addr == addr))
      return write_data;
    else
      return regs[addr];
  endfunction

  assign read_data1 = read_port(read_addr1);
  assign read_data2 = read_port(read_addr2);

endmodule

// File: rtl/mips_register_writeback_file.sv
// Executes the decode-stage register control word: resolves read/write
// addresses, reads the register file into registered outputs, tracks
// in-flight writes through a DEPTH-stage pending pipeline (stalling issue on
// read-after-write hazards) and commits ALU/memory/PC data at writeback.
//   clock, reset                   : clock, synchronous active-high reset
//   issue_valid / issue_stall      : issue handshake with decode
//   rs, rt, rd                     : instruction register fields
//   port1/port2_addr_source        : read address selects
//   write_addr/data_source, write_enable : destination control
//   read_data1/2                   : registered read data
//   wb_alu, wb_memory, wb_pc       : writeback candidates for the final stage
//   wb_commit, wb_addr             : register write happening this cycle
module mips_register_writeback_file
  import mips_register_writeback_file_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_stall,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic                  port1_addr_source,
  input  logic                  port2_addr_source,
  input  logic [1:0]            write_addr_source,
  input  logic [1:0]            write_data_source,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [DATA_WIDTH-1:0] wb_alu,
  input  logic [DATA_WIDTH-1:0] wb_memory,
  input  logic [DATA_WIDTH-1:0] wb_pc,
  output logic                  wb_commit,
  output logic [4:0]            wb_addr
);

  logic [4:0]            a1, a2, dst;
  logic                  eff_we, accept, hazard;
  pending_entry_t        pending [DEPTH];
  pending_entry_t        tail;
  logic [DATA_WIDTH-1:0] commit_data, core_rd1, core_rd2;

  function automatic logic [DATA_WIDTH-1:0] select_wb_data(
    input write_data_source_t src,
    input logic [DATA_WIDTH-1:0] alu,
    input logic [DATA_WIDTH-1:0] mem,
    input logic [DATA_WIDTH-1:0] pc
  );
    case (src)
      WDATA_MEMORY: return mem;
      WDATA_PC:     return pc;
      default:      return alu;
    endcase
  endfunction

  assign a1 = (port1_addr_source == PORT1_RT) ? rt : rs;
  assign a2 = (port2_addr_source == PORT2_RS) ? rs : rt;

  always_comb begin
    case (write_addr_source)
      WADDR_RT:  dst = rt;
      WADDR_RD:  dst = rd;
      WADDR_R31: dst = 5'd31;
      default:   dst = 5'd0;
    endcase
  end

  assign eff_we = write_enable && (write_addr_source != WADDR_RSVD) &&
                  (write_data_source != WDATA_RSVD) && (dst != 5'd0);

  // The final stage is not checked: its data is bypassed by the core.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (pending[i].valid && (pending[i].dst != 5'd0) &&
          ((pending[i].dst == a1) || (pending[i].dst == a2)))
        hazard = 1'b1;
    end
  end

  assign issue_stall = issue_valid && hazard;
  assign accept      = issue_valid && !hazard;

  // Pending pipeline: always advances; a refused or non-writing issue
  // inserts an all-zero bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pending[i] <= '0;
    end else begin
      if (accept && eff_we)
        pending[0] <= '{valid: 1'b1, dst: dst,
                        data_source: write_data_source_t'(write_data_source)};
      else
        pending[0] <= '0;
      for (int i = 1; i < DEPTH; i++) pending[i] <= pending[i-1];
    end
  end

  // Writeback stage
  assign tail        = pending[DEPTH-1];
  assign wb_commit   = tail.valid;
  assign wb_addr     = tail.dst;
  assign commit_data = select_wb_data(tail.data_source, wb_alu, wb_memory, wb_pc);

  mips_register_file_core #(
    .DATA_W (DATA_WIDTH)
  ) u_core (
    .clock        (clock),
    .reset        (reset),
    .write_enable (wb_commit),
    .write_addr   (wb_addr),
    .write_data   (commit_data),
    .read_addr1   (a1),
    .read_addr2   (a2),
    .read_data1   (core_rd1),
    .read_data2   (core_rd2)
  );

  // Read stage: outputs only change on an accepted issue
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data1 <= '0;
      read_data2 <= '0;
    end else if (accept) begin
      read_data1 <= core_rd1;
      read_data2 <= core_rd2;
    end
  end

endmodule

// File: tb/tb_mips_register_writeback_file.sv
module tb_mips_register_writeback_file;

  localparam int DEPTH = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_stall;
  logic [4:0]  rs, rt, rd;
  logic        port1_addr_source, port2_addr_source;
  logic [1:0]  write_addr_source, write_data_source;
  logic        write_enable;
  logic [31:0] read_data1, read_data2;
  logic [31:0] wb_alu, wb_memory, wb_pc;
  logic        wb_commit;
  logic [4:0]  wb_addr;

  always #5 clock = ~clock;

  mips_register_writeback_file #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_stall       (issue_stall),
    .rs                (rs),
    .rt                (rt),
    .rd                (rd),
    .port1_addr_source (port1_addr_source),
    .port2_addr_source (port2_addr_source),
    .write_addr_source (write_addr_source),
    .write_data_source (write_data_source),
    .write_enable      (write_enable),
    .read_data1        (read_data1),
    .read_data2        (read_data2),
    .wb_alu            (wb_alu),
    .wb_memory         (wb_memory),
    .wb_pc             (wb_pc),
    .wb_commit         (wb_commit),
    .wb_addr           (wb_addr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural registers plus a list of outstanding
  // writes, each with the number of cycles left before it commits.
  typedef struct {
    int dst;
    int src;
    int rem;
  } pw_t;

  logic [31:0] m_regs [32];
  pw_t         m_pend [$];
  logic [31:0] m_rd1, m_rd2;
  logic        obs_stall;
  logic        last_stall;

  function automatic int m_a1();
    return port1_addr_source ? int'(rt) : int'(rs);
  endfunction

  function automatic int m_a2();
    return port2_addr_source ? int'(rs) : int'(rt);
  endfunction

  function automatic int m_dst();
    case (write_addr_source)
      2'd0:    return int'(rt);
      2'd1:    return int'(rd);
      2'd2:    return 31;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_eff();
    return write_enable && write_addr_source != 2'd3 &&
           write_data_source != 2'd3 && m_dst() != 0;
  endfunction

  function automatic bit m_stall();
    bit h = 0;
    foreach (m_pend[i])
      if (m_pend[i].rem > 0 &&
          ((m_a1() != 0 && m_pend[i].dst == m_a1()) ||
           (m_a2() != 0 && m_pend[i].dst == m_a2())))
        h = 1;
    return issue_valid && h;
  endfunction

  function automatic int m_commit_idx();
    foreach (m_pend[i]) if (m_pend[i].rem == 0) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_sel(input int src);
    case (src)
      1:       return wb_memory;
      2:       return wb_pc;
      default: return wb_alu;
    endcase
  endfunction

  // Called right after inputs are driven on a falling edge; returns on the
  // next falling edge.
  task automatic step();
    bit  exp_stall, accepted;
    int  ci;
    pw_t nq [$];
    #1;
    exp_stall = m_stall();
    obs_stall = issue_stall;
    check("issue_stall", {31'd0, issue_stall}, {31'd0, exp_stall});
    ci = m_commit_idx();
    check("wb_commit", {31'd0, wb_commit}, {31'd0, ci >= 0});
    if (ci >= 0) check("wb_addr", {27'd0, wb_addr}, 32'(m_pend[ci].dst));
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend.delete();
      m_rd1 = '0;
      m_rd2 = '0;
    end else begin
      if (ci >= 0) m_regs[m_pend[ci].dst] = m_sel(m_pend[ci].src);
      accepted = issue_valid && !exp_stall;
      if (accepted) begin
        m_rd1 = (m_a1() == 0) ? 32'd0 : m_regs[m_a1()];
        m_rd2 = (m_a2() == 0) ? 32'd0 : m_regs[m_a2()];
      end
      foreach (m_pend[i])
        if (m_pend[i].rem > 0) nq.push_back('{m_pend[i].dst, m_pend[i].src, m_pend[i].rem - 1});
      if (accepted && m_eff())
        nq.push_back('{m_dst(), int'(write_data_source), DEPTH - 1});
      m_pend = nq;
    end
    last_stall = exp_stall;
    #1;
    check("read_data1", read_data1, m_rd1);
    check("read_data2", read_data2, m_rd2);
    @(negedge clock);
  endtask

  task automatic set_instr(input logic v, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic p1, input logic p2,
                           input logic [1:0] wa, input logic [1:0] wd, input logic we);
    issue_valid = v; rs = s; rt = t; rd = d;
    port1_addr_source = p1; port2_addr_source = p2;
    write_addr_source = wa; write_data_source = wd; write_enable = we;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    write_enable = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // addi-style write of value into register t, then drain to commit
  task automatic write_reg(input logic [4:0] t, input logic [31:0] value);
    wb_alu = value;
    set_instr(1'b1, 5'd0, t, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    step();
    idle(DEPTH);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_rd1 = '0; m_rd2 = '0; last_stall = 1'b0; obs_stall = 1'b0;
    reset = 1'b1;
    wb_alu = '0; wb_memory = '0; wb_pc = '0;
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clock);
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_read_data1", read_data1, 32'd0);
    check("rst_read_data2", read_data2, 32'd0);
    check("rst_wb_commit", {31'd0, wb_commit}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_issue_stall", {31'd0, issue_stall}, 32'd0);
    @(negedge clock);

    // addi r5 = 0x1234, then read r5
    write_reg(5'd5, 32'h1234);
    set_instr(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step();
    check("addi_r5", read_data1, 32'h1234);

    // RAW hazard: write r8, then read r8 stalls twice, accepted on bypass
    wb_alu = 32'hCAFE;
    set_instr(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1);
    step();
    set_instr(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step();
    check("raw_stall_1", {31'd0, obs_stall}, 32'd1);
    step();
    check("raw_stall_2", {31'd0, obs_stall}, 32'd1);
    step();
    check("raw_accept", {31'd0, obs_stall}, 32'd0);
    check("raw_bypass", read_data1, 32'hCAFE);

    // Link: r31 <= pc, alu ignored
    wb_alu = 32'hDEAD_BEEF; wb_pc = 32'h0040_0010;
    set_instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1);
    step();
    idle(DEPTH);
    set_instr(1'b1, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step();
    check("link_r31", read_data1, 32'h0040_0010);

    // Shift: port1 from rt (r3), port2 from rs (r4)
    write_reg(5'd3, 32'd7);
    write_reg(5'd4, 32'd2);
    set_instr(1'b1, 5'd4, 5'd3, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    step();
    check("shift_rd1", read_data1, 32'd7);
    check("shift_rd2", read_data2, 32'd2);

    // Write to r0 and a store: neither creates a pending write
    wb_alu = 32'h5555_AAAA;
    set_instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    step();
    set_instr(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
    step();
    set_instr(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step();
    check("nowrite_stall", {31'd0, obs_stall}, 32'd0);
    check("r0_reads_zero", read_data1, 32'd0);
    check("store_no_write", read_data2, 32'd0);
    idle(DEPTH);

    // Reset with two writes pending discards them and clears the file
    wb_alu = 32'h1111_2222;
    set_instr(1'b1, 5'd0, 5'd10, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    step();
    set_instr(1'b1, 5'd0, 5'd11, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    step();
    issue_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(DEPTH + 1);
    set_instr(1'b1, 5'd10, 5'd11, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step();
    check("rst_pend_r10", read_data1, 32'd0);
    check("rst_pend_r11", read_data2, 32'd0);
    set_instr(1'b1, 5'd5, 5'd31, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step();
    check("rst_clear_r5", read_data1, 32'd0);
    check("rst_clear_r31", read_data2, 32'd0);

    // Randomized traffic; decode holds its word while stalled
    for (int n = 0; n < 600; n++) begin
      wb_alu = $urandom; wb_memory = $urandom; wb_pc = $urandom;
      reset = ($urandom_range(0, 79) == 0);
      if (!(last_stall && issue_valid)) begin
        issue_valid       = ($urandom_range(0, 3) != 0);
        rs                = 5'($urandom_range(0, 7));
        rt                = 5'($urandom_range(0, 7));
        rd                = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        port1_addr_source = 1'($urandom_range(0, 1));
        port2_addr_source = 1'($urandom_range(0, 1));
        write_addr_source = 2'($urandom_range(0, 3));
        write_data_source = 2'($urandom_range(0, 3));
        write_enable      = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_register_writeback_file.md
Name: mips_register_writeback_file

Overview:
- Consumes the register control word produced at decode (port address sources, write address source, write data source, write enable) and executes it.
- Resolves read addresses and reads a 32x32 register file, with 1-cycle registered read data.
- Tracks in-flight writes through a DEPTH-stage pending pipeline and stalls issue on read-after-write hazards.
- At writeback, selects ALU, memory or PC data and commits it to the register file.

Parameters:
DEPTH, 3, number of pipeline stages between issue and writeback commit (range 1..4)
DATA_WIDTH, 32, register data width

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
issue_valid  input  1  decode presents an instruction this cycle
issue_stall  output  1  issue refused this cycle; decode must hold its inputs
rs  input  5  instruction rs field
rt  input  5  instruction rt field
rd  input  5  instruction rd field
port1_addr_source  input  1  0=Rs, 1=Rt
port2_addr_source  input  1  0=Rt, 1=Rs
write_addr_source  input  2  0=Rt, 1=Rd, 2=R31, 3=reserved
write_data_source  input  2  0=Alu, 1=Memory, 2=Pc, 3=reserved
write_enable  input  1  instruction writes a register
read_data1  output  DATA_WIDTH  port-1 data, valid the cycle after issue is accepted
read_data2  output  DATA_WIDTH  port-2 data, same timing as read_data1
wb_alu  input  DATA_WIDTH  ALU result for the instruction in the final stage
wb_memory  input  DATA_WIDTH  load data for the final stage
wb_pc  input  DATA_WIDTH  link address for the final stage
wb_commit  output  1  a register write happens this cycle
wb_addr  output  5  address being written when wb_commit=1

Behaviour:
- Reset: all pending entries invalid; read_data1/2=0; issue_stall=0; wb_commit=0; wb_addr=0; register file cleared to 0.
- Address resolution (combinational):
  - a1 = port1_addr_source ? rt : rs.
  - a2 = port2_addr_source ? rs : rt.
  - dst = rt, rd or 31 per write_addr_source.
- Entry enable: eff_we = write_enable && write_addr_source!=3 && write_data_source!=3 && dst!=0.
- Pending pipeline:
  - Entry = {valid, dst, data_source}. Stage 0 loads on accepted issue (valid=eff_we); otherwise a bubble (valid=0) is inserted.
  - Entries shift one stage per cycle unconditionally; a stall never freezes stages.
- Commit: when stage DEPTH-1 is valid, write mux(data_source: wb_alu/wb_memory/wb_pc) to dst at that edge. wb_commit/wb_addr reflect stage DEPTH-1 combinationally.
- Hazard:
  - issue_stall = issue_valid && (a1 or a2 matches dst of any valid entry in stages 0..DEPTH-2), with address 0 never matching.
  - Stage DEPTH-1 does not stall; it is bypassed.
- Reads: on accepted issue (issue_valid && !issue_stall), read_data1/2 <= (a==0) ? 0 : (commit this cycle to a ? committed data : regfile[a]).
  - Otherwise read_data1/2 hold their previous values.
- Register 0: never written, always reads 0.
- Simultaneous events: commit and issue in the same cycle is legal. A read of the committing address returns the new data via the bypass.
- Reset mid-operation: pending writes are discarded, not committed; register contents are cleared.

Decomposition:
- Shared package: source encodings (Port1/Port2/WriteAddr/WriteData) and the pending-entry struct width.
- Natural sub-module: mips_register_file_core (32 entries, 2 read ports, 1 write port, r0 hardwired, internal write-to-read bypass).

Test Plan:
- Reset, then issue addi-style (write_addr_source=Rt, rt=5, Alu, we=1); after 3 cycles wb_alu=0x1234 -> wb_commit=1, wb_addr=5. A later read of r5 gives read_data1=0x1234.
- Issue write r8, then next cycle issue read rs=8 -> issue_stall=1 for 2 cycles. Accepted on the third, when the final stage bypasses: read_data1=wb value 0xCAFE.
- Link instruction (write_addr_source=R31, Pc, wb_pc=0x400010) -> commit to r31 with 0x400010; wb_alu ignored.
- Shift instruction (port1 source=Rt=3, port2 source=Rs=4, r3=7, r4=2) -> read_data1=7, read_data2=2.
- Writes to r0, and a store (we=0) -> no commit, no stall on subsequent reads of that address, r0 reads 0.
- Reset asserted with 2 writes pending -> no commit after reset deassert; all reads return 0.
